// File: rtl/iter_divider_if.sv
// Request/result bundle between the EX stage (master) and the iterative divider (slave).
interface iter_divider_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  signed_op;
  logic                  cancel;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  ready;
  logic                  stall_req;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output start, signed_op, cancel, dividend, divisor,
    input  ready, stall_req, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, cancel, dividend, divisor,
    output ready, stall_req, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned with
// cancel, divide-by-zero shortcut and back-to-back issue from the DONE cycle.
module iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  iter_divider_if.slave div
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [W-1:0]   quo_out_q, quo_out_d;
  logic [W-1:0]   rem_out_q, rem_out_d;
  logic           dbz_q, dbz_d;

  logic           ready;
  logic           accept;
  logic           last_iter;
  logic           divisor_zero;
  logic [W:0]     shifted;
  logic [W+1:0]   diff;
  logic           qbit;
  logic [W:0]     rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = divisor_zero ? DONE : CALC;
        else        state_d = IDLE;
      end
      CALC: begin
        if (div.cancel)     state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready            = (state_q == IDLE) || (state_q == DONE);
    accept           = ready && div.start && !div.cancel;
    div.ready        = ready;
    div.done         = (state_q == DONE);
    div.stall_req    = !rst && (accept || (state_q == CALC));
    div.quotient     = quo_out_q;
    div.remainder    = rem_out_q;
    div.div_by_zero  = dbz_q;
  end

  assign divisor_zero = (div.divisor == '0);
  assign last_iter    = (cnt_q == CW'(W - 1));

  // One restoring step: shift in the next dividend bit, trial-subtract |divisor|
  always_comb begin
    shifted  = {rem_q[W-1:0], dvd_q[W-1]};
    diff     = {1'b0, shifted} - {2'b00, dvs_q};
    qbit     = !diff[W+1];
    rem_next = qbit ? diff[W:0] : shifted;
    quo_next = {dvd_q[W-2:0], qbit};
    mag_a    = (div.signed_op && div.dividend[W-1]) ? -div.dividend : div.dividend;
    mag_b    = (div.signed_op && div.divisor[W-1])  ? -div.divisor  : div.divisor;
  end

  always_comb begin
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_d     = dbz_q;
    if (accept) begin
      dvd_d  = mag_a;
      dvs_d  = mag_b;
      rem_d  = '0;
      cnt_d  = '0;
      qneg_d = div.signed_op && (div.dividend[W-1] ^ div.divisor[W-1]);
      rneg_d = div.signed_op && div.dividend[W-1];
      if (divisor_zero) begin
        quo_out_d = '1;
        rem_out_d = div.dividend;
        dbz_d     = 1'b1;
      end
    end else if ((state_q == CALC) && !div.cancel) begin
      dvd_d = quo_next;
      rem_d = rem_next;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        // Most-negative / -1 wraps naturally: |q| = 2^(W-1) negates to itself
        quo_out_d = qneg_q ? -quo_next : quo_next;
        rem_out_d = rneg_q ? -rem_next[W-1:0] : rem_next[W-1:0];
        dbz_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_q     <= dbz_d;
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_iter_divider;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  iter_divider_if #(.DATA_WIDTH(32)) if32 ();
  iter_divider_if #(.DATA_WIDTH(8))  if8 ();

  iter_divider #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .div(if32));
  iter_divider #(.DATA_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .div(if8));

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic (truncating division) on sign-extended operands
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn, output logic [31:0] q, output logic [31:0] r,
                                  output logic dbz, output int lat);
    logic [31:0] mask, am, bm;
    longint sa, sb, qq, rr;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = a & mask;
    bm = b & mask;
    if (bm == 32'd0) begin
      q = mask; r = am; dbz = 1'b1; lat = 1;
      return;
    end
    sa = $signed({32'd0, am});
    sb = $signed({32'd0, bm});
    if (sgn && am[w-1]) sa = sa - (64'sd1 <<< w);
    if (sgn && bm[w-1]) sb = sb - (64'sd1 <<< w);
    qq = sa / sb;
    rr = sa % sb;
    q = qq[31:0] & mask;
    r = rr[31:0] & mask;
    dbz = 1'b0;
    lat = w + 1;
  endfunction

  // Called at a negedge: present a request, then drop start after the edge
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    if32.start = 1'b1; if32.signed_op = sgn; if32.dividend = a; if32.divisor = b;
    #1;
    chk("ready_at_req", 64'(if32.ready), 64'd1);
    chk("stall_at_req", 64'(if32.stall_req), 64'd1);
    @(posedge clk); #1;
    if32.start = 1'b0;
  endtask

  task automatic wait_done32(input logic hold, input logic [31:0] hq, input logic [31:0] hr,
                             output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if32.done) begin lat = c; break; end
      chk("stall_in_calc", 64'(if32.stall_req), 64'd1);
      if (hold) begin
        chk("held_quotient", 64'(if32.quotient), 64'(hq));
        chk("held_remainder", 64'(if32.remainder), 64'(hr));
      end
    end
    if (lat == 0) chk("done_timeout", 64'd0, 64'd1);
    else          chk("stall_at_done", 64'(if32.stall_req), 64'd0);
  endtask

  task automatic run_check32(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                             input logic edbz);
    int lat;
    @(negedge clk);
    issue32(a, b, sgn);
    wait_done32(1'b0, '0, '0, lat);
    chk({nm, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    chk({nm, "_quotient"}, 64'(if32.quotient), 64'(eq));
    chk({nm, "_remainder"}, 64'(if32.remainder), 64'(er));
    chk({nm, "_dbz"}, 64'(if32.div_by_zero), 64'(edbz));
  endtask

  task automatic run_check8(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic sgn);
    logic [31:0] eq, er;
    logic        edbz;
    int          elat, lat;
    ref_div(8, {24'd0, a}, {24'd0, b}, sgn, eq, er, edbz, elat);
    @(negedge clk);
    if8.start = 1'b1; if8.signed_op = sgn; if8.dividend = a; if8.divisor = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if8.done) begin lat = c; break; end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_quotient"}, 64'(if8.quotient), 64'(eq[7:0]));
    chk({nm, "_remainder"}, 64'(if8.remainder), 64'(er[7:0]));
    chk({nm, "_dbz"}, 64'(if8.div_by_zero), 64'(edbz));
  endtask

  task automatic expect_no_done(input string nm, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk(nm, 64'(if32.done), 64'd0);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] a, b, eq, er;
    logic        sgn, edbz;
    int          elat;

    tbl[0] = '{"u100_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    tbl[1] = '{"s-7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{"s7_-2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[3] = '{"u5_0",      32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
    tbl[4] = '{"s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    tbl[5] = '{"s-100_-7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0};
    tbl[6] = '{"u_big",     32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
    tbl[7] = '{"s-5_0",     32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};

    rst = 1'b1;
    if32.start = 1'b1; if32.signed_op = 1'b0; if32.cancel = 1'b0;
    if32.dividend = 32'd9; if32.divisor = 32'd3;
    if8.start = 1'b0; if8.signed_op = 1'b0; if8.cancel = 1'b0;
    if8.dividend = '0; if8.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_quotient", 64'(if32.quotient), 64'd0);
    chk("rst_remainder", 64'(if32.remainder), 64'd0);
    chk("rst_dbz", 64'(if32.div_by_zero), 64'd0);
    chk("rst_done", 64'(if32.done), 64'd0);
    chk("rst_ready", 64'(if32.ready), 64'd1);
    chk("rst_stall", 64'(if32.stall_req), 64'd0);
    if32.start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_check32(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].q, tbl[i].r, tbl[i].dbz);

    // Cancel in CALC cycle 10 after a known 100/7 result
    run_check32("pre_cancel", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    issue32(32'd5000, 32'd9, 1'b0);
    repeat (10) @(negedge clk);
    if32.cancel = 1'b1;
    @(posedge clk); #1;
    if32.cancel = 1'b0;
    chk("cancel_ready", 64'(if32.ready), 64'd1);
    chk("cancel_done", 64'(if32.done), 64'd0);
    chk("cancel_quotient", 64'(if32.quotient), 64'd14);
    chk("cancel_remainder", 64'(if32.remainder), 64'd2);
    expect_no_done("cancel_no_done", 40);
    run_check32("after_cancel", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    // start together with cancel is ignored
    @(negedge clk);
    if32.start = 1'b1; if32.cancel = 1'b1; if32.dividend = 32'd50; if32.divisor = 32'd5;
    #1;
    chk("startcancel_stall", 64'(if32.stall_req), 64'd0);
    @(posedge clk); #1;
    if32.start = 1'b0; if32.cancel = 1'b0;
    chk("startcancel_ready", 64'(if32.ready), 64'd1);
    chk("startcancel_stall2", 64'(if32.stall_req), 64'd0);
    expect_no_done("startcancel_no_done", 3);

    // Reset mid-CALC
    @(negedge clk);
    issue32(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_quotient", 64'(if32.quotient), 64'd0);
    chk("midrst_remainder", 64'(if32.remainder), 64'd0);
    chk("midrst_dbz", 64'(if32.div_by_zero), 64'd0);
    chk("midrst_ready", 64'(if32.ready), 64'd1);
    chk("midrst_stall", 64'(if32.stall_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_no_done("midrst_no_done", 40);

    // Back-to-back: second start in the done cycle of the first
    @(negedge clk);
    issue32(32'd100, 32'd7, 1'b0);
    wait_done32(1'b0, '0, '0, lat);
    chk("b2b_first_latency", 64'(lat), 64'd33);
    chk("b2b_first_quotient", 64'(if32.quotient), 64'd14);
    chk("b2b_first_remainder", 64'(if32.remainder), 64'd2);
    issue32(32'd20, 32'd6, 1'b0);
    wait_done32(1'b1, 32'd14, 32'd2, lat);
    chk("b2b_second_latency", 64'(lat), 64'd33);
    chk("b2b_second_quotient", 64'(if32.quotient), 64'd3);
    chk("b2b_second_remainder", 64'(if32.remainder), 64'd2);

    // Randomized 32-bit operations
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sgn = 1'($urandom_range(0, 1));
      ref_div(32, a, b, sgn, eq, er, edbz, elat);
      run_check32("rand32", a, b, sgn, eq, er, edbz);
    end

    // 8-bit instance
    run_check8("u8_200_3", 8'd200, 8'd3, 1'b0);
    run_check8("s8_ovf", 8'h80, 8'hFF, 1'b1);
    for (int i = 0; i < 20; i++)
      run_check8("rand8", 8'($urandom), 8'($urandom_range(0, 255) >> $urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
